// File: rtl/pkg_7seg.sv
// pkg_7seg: shared font table, blank pattern, scan FSM states and width helper for the 7-segment driver
package pkg_7seg;
  localparam logic [7:0] SEG_APAGADO = 8'hFF;
  localparam logic [6:0] FONTE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic {MORTO, EXIBE} estado_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/dec_hex_7seg.sv
// dec_hex_7seg: nibble + dp + blank -> active-low {dp,a,b,c,d,e,f,g}
//   i_nib   hex digit to show
//   i_dp    decimal point, active-low
//   i_apaga 1 = segments a..g all off (dp still follows i_dp)
//   o_seg   active-low segment pattern
module dec_hex_7seg import pkg_7seg::*; (
  input  logic [3:0] i_nib,
  input  logic       i_dp,
  input  logic       i_apaga,
  output logic [7:0] o_seg
);
  assign o_seg = {i_dp, i_apaga ? 7'h7F : FONTE[i_nib]};
endmodule

// File: rtl/multiplexador_7seg.sv
// multiplexador_7seg: time-multiplexed N-digit common-anode 7-segment driver with dead time and zero blanking
//   clk, rst_n   clock, asynchronous active-low reset
//   valores      packed hex nibbles, digit 0 rightmost
//   pontos       per-digit decimal point, 0 = lit
//   habilita     per-digit enable, 0 = digit dark
//   carrega      one-cycle load strobe for valores/pontos/habilita
//   saida_seg    {dp,a..g}, active-low, registered
//   anodos       digit selects, active-low, registered
//   ocupado_idx  index of the digit owning the current slot
module multiplexador_7seg import pkg_7seg::*; #(
  parameter int N_DIGITOS     = 4,
  parameter int DIV_REFRESH   = 50000,
  parameter int T_MORTO       = 500,
  parameter int SUPRIME_ZEROS = 1,
  localparam int IW = (N_DIGITOS > 1) ? clog2(N_DIGITOS) : 1,
  localparam int CW = clog2(DIV_REFRESH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*N_DIGITOS-1:0] valores,
  input  logic [N_DIGITOS-1:0]   pontos,
  input  logic [N_DIGITOS-1:0]   habilita,
  input  logic                   carrega,
  output logic [7:0]             saida_seg,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic [IW-1:0]          ocupado_idx
);
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  estado_t                r_estado;
  logic [4*N_DIGITOS-1:0] r_stg_val, r_sh_val;
  logic [N_DIGITOS-1:0]   r_stg_pts, r_stg_hab, r_sh_pts, r_sh_hab;
  logic [7:0]             r_seg;
  logic [N_DIGITOS-1:0]   r_an;
  logic                   w_fim, w_lat, w_apaga;
  logic [IW-1:0]          w_idx_prox;
  logic [N_DIGITOS-1:0]   w_zero;
  logic [7:0]             w_padrao, w_seg_lat;
  logic [N_DIGITOS-1:0]   w_an_lat;

  // w_zero[i]: nibble i and every higher nibble of the shadow are zero
  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_zero
    assign w_zero[i] = ~|r_sh_val[4*N_DIGITOS-1:4*i];
  end

  assign w_fim      = r_cnt == CW'(DIV_REFRESH - 1);
  assign w_lat      = (r_estado == MORTO) && (r_cnt == CW'(T_MORTO - 1));
  assign w_idx_prox = (r_idx == IW'(N_DIGITOS - 1)) ? '0 : r_idx + 1'b1;
  assign w_apaga    = (SUPRIME_ZEROS != 0) && (r_idx != '0) && w_zero[r_idx];

  dec_hex_7seg u_dec (
    .i_nib  (r_sh_val[4*r_idx +: 4]),
    .i_dp   (r_sh_pts[r_idx]),
    .i_apaga(w_apaga),
    .o_seg  (w_padrao)
  );

  // a disabled digit stays fully dark, segments included
  assign w_seg_lat = r_sh_hab[r_idx] ? w_padrao : SEG_APAGADO;
  assign w_an_lat  = r_sh_hab[r_idx] ? ~(N_DIGITOS'(1) << r_idx) : '1;

  // carrega lands in a staging copy; the shadow that feeds the display only
  // advances on the slot wrap, so a lit digit never changes mid-slot and a
  // strobe on the wrap edge itself waits one more slot
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_estado  <= MORTO;
      r_stg_val <= '0;
      r_stg_pts <= '1;
      r_stg_hab <= '0;
      r_sh_val  <= '0;
      r_sh_pts  <= '1;
      r_sh_hab  <= '0;
      r_seg     <= SEG_APAGADO;
      r_an      <= '1;
    end else begin
      if (carrega) begin
        r_stg_val <= valores;
        r_stg_pts <= pontos;
        r_stg_hab <= habilita;
      end
      if (w_fim) begin
        r_cnt    <= '0;
        r_idx    <= w_idx_prox;
        r_estado <= MORTO;
        r_sh_val <= r_stg_val;
        r_sh_pts <= r_stg_pts;
        r_sh_hab <= r_stg_hab;
        r_seg    <= SEG_APAGADO;
        r_an     <= '1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (w_lat) begin
          r_estado <= EXIBE;
          r_seg    <= w_seg_lat;
          r_an     <= w_an_lat;
        end
      end
    end

  assign saida_seg   = r_seg;
  assign anodos      = r_an;
  assign ocupado_idx = r_idx;
endmodule

// File: tb/tb_multiplexador_7seg.sv
// tb_multiplexador_7seg: directed scan checks against a slot-level display model through a scoreboard queue
module tb_multiplexador_7seg;
  localparam int N = 4, DIV = 8, TM = 2;
  logic clk = 0, rst_n = 0, carrega = 0;
  logic [15:0] valores = '0;
  logic [3:0] pontos = '1, habilita = '0;
  logic [7:0] saida_seg;
  logic [3:0] anodos;
  logic [1:0] ocupado_idx;
  typedef struct packed {logic [7:0] seg; logic [3:0] an; logic [1:0] idx;} exp_t;
  exp_t q[$];
  int nchk = 0, npass = 0, g = 0, pn_s = -1;
  logic [15:0] ef_v = '0, pn_v = '0;
  logic [3:0] ef_p = '1, ef_h = '0, pn_p = '1, pn_h = '0;
  logic [6:0] font [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  multiplexador_7seg #(.N_DIGITOS(N), .DIV_REFRESH(DIV), .T_MORTO(TM), .SUPRIME_ZEROS(1)) dut (
    .clk(clk), .rst_n(rst_n), .valores(valores), .pontos(pontos), .habilita(habilita),
    .carrega(carrega), .saida_seg(saida_seg), .anodos(anodos), .ocupado_idx(ocupado_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nchk++;
    assert (got === exp) npass++;
    else $error("FAIL %s g=%0d got %h expected %h", tag, g, got, exp);
  endtask

  function automatic exp_t model(input int gg);
    exp_t e;
    int d, c;
    logic [3:0] nib;
    logic blank;
    d = (gg / DIV) % N;
    c = gg % DIV;
    e.idx = 2'(d);
    e.seg = 8'hFF;
    e.an = 4'hF;
    if (c >= TM && ef_h[d]) begin
      nib = ef_v[4*d +: 4];
      blank = (d > 0) && ((ef_v >> (4*d)) == 16'h0);
      e.seg = {ef_p[d], blank ? 7'h7F : font[nib]};
      e.an = ~(4'b0001 << d);
    end
    return e;
  endfunction

  task automatic step(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (pn_s >= 0 && g / DIV >= pn_s) begin
        ef_v = pn_v; ef_p = pn_p; ef_h = pn_h; pn_s = -1;
      end
      q.push_back(model(g));
      e = q.pop_front();
      chk("seg", saida_seg, e.seg);
      chk("anodos", {4'h0, anodos}, {4'h0, e.an});
      chk("idx", {6'h0, ocupado_idx}, {6'h0, e.idx});
      chk("one_anode", 8'($countones(~anodos) <= 1), 8'd1);
      g++;
      @(negedge clk);
      carrega = 0;
    end
  endtask

  // the strobe is sampled on the edge after sample g; it reaches the display
  // on the next slot, or one slot later if that edge is itself the wrap
  task automatic load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] h);
    valores = v; pontos = p; habilita = h; carrega = 1;
    pn_v = v; pn_p = p; pn_h = h;
    pn_s = g / DIV + ((g % DIV == DIV - 1) ? 2 : 1);
  endtask

  task automatic chk_reset();
    chk("rst_seg", saida_seg, 8'hFF);
    chk("rst_anodos", {4'h0, anodos}, 8'h0F);
    chk("rst_idx", {6'h0, ocupado_idx}, 8'h00);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset();
    rst_n = 1;
    @(negedge clk);
    g = 0;
    step(64);
    load(16'h12AF, 4'b1111, 4'b1111); step(40);
    load(16'h0030, 4'b1011, 4'b1111); step(40);
    step(31);
    load(16'h0700, 4'b1111, 4'b1111); step(49);
    load(16'h1234, 4'b1111, 4'b1010); step(40);
    step(13);
    #2 rst_n = 0;
    #1 chk_reset();
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    g = 0; ef_v = '0; ef_p = '1; ef_h = '0; pn_s = -1;
    q.delete();
    step(8);
    load(16'h00A0, 4'b1110, 4'b1111); step(40);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
